// File: rtl/game_frame_scanner.sv
// Row-multiplexed LED matrix scanner: snapshots the game state at frame start and paces generation steps.
// Optional inter-row blanking is compiled in with `define GAME_SCANNER_BLANK_EN.
module game_frame_scanner #(
   parameter int ROWS            = 8,
   parameter int COLS            = 8,
   parameter int DWELL           = 1000,
   parameter int BLANK_CYCLES    = 16,
   parameter int FRAMES_PER_STEP = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ROWS*COLS-1:0] game_in,
   input  logic                 en,
   output logic [ROWS-1:0]      row_sel,
   output logic [COLS-1:0]      col_data,
   output logic                 frame_done,
   output logic                 step
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int FC_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL - 1);
   localparam logic [FC_W-1:0]  FCNT_LAST  = FC_W'(FRAMES_PER_STEP - 1);

`ifdef GAME_SCANNER_BLANK_EN
   localparam int BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [BLK_W-1:0] BLANK_LAST = BLK_W'(BLANK_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SCAN, BLANK} state_t;

   logic [BLK_W-1:0] blank_q, blank_d;
`else
   typedef enum logic [1:0] {IDLE, LOAD, SCAN} state_t;
`endif

   state_t                 state_q, state_d;
   logic [ROW_W-1:0]       row_q, row_d;
   logic [DW_W-1:0]        dwell_q, dwell_d;
   logic [FC_W-1:0]        fcnt_q, fcnt_d;
   logic [ROWS*COLS-1:0]   snap_q, snap_d;
   logic [ROWS-1:0]        row_sel_q, row_sel_d;
   logic [COLS-1:0]        col_data_q, col_data_d;
   logic                   frame_done_q, frame_done_d;
   logic                   step_q, step_d;
   logic                   eof;

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      dwell_d      = dwell_q;
      fcnt_d       = fcnt_q;
      snap_d       = snap_q;
      eof          = 1'b0;
`ifdef GAME_SCANNER_BLANK_EN
      blank_d      = blank_q;
`endif

      case (state_q)
         IDLE: begin
            if (en) state_d = LOAD;
         end
         LOAD: begin
            snap_d  = game_in;
            row_d   = '0;
            dwell_d = '0;
            state_d = SCAN;
         end
         SCAN: begin
            if (dwell_q == DWELL_LAST) begin
               dwell_d = '0;
`ifdef GAME_SCANNER_BLANK_EN
               blank_d = '0;
               state_d = BLANK;
`else
               if (row_q == ROW_LAST) begin
                  eof     = 1'b1;
                  state_d = en ? LOAD : IDLE;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
`endif
            end else begin
               dwell_d = dwell_q + DW_W'(1);
            end
         end
`ifdef GAME_SCANNER_BLANK_EN
         BLANK: begin
            if (blank_q == BLANK_LAST) begin
               blank_d = '0;
               if (row_q == ROW_LAST) begin
                  eof     = 1'b1;
                  state_d = en ? LOAD : IDLE;
               end else begin
                  row_d   = row_q + ROW_W'(1);
                  state_d = SCAN;
               end
            end else begin
               blank_d = blank_q + BLK_W'(1);
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      // Drive from the current state so row_sel and col_data always change on the same edge.
      row_sel_d  = '0;
      col_data_d = '0;
      if (state_q == SCAN) begin
         row_sel_d  = ROWS'(1) << row_q;
         col_data_d = snap_q[32'(row_q)*COLS +: COLS];
      end

      frame_done_d = eof;
      step_d       = eof && (fcnt_q == FCNT_LAST);
      if (eof) fcnt_d = step_d ? '0 : fcnt_q + FC_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         row_q        <= '0;
         dwell_q      <= '0;
         fcnt_q       <= '0;
         snap_q       <= '0;
         row_sel_q    <= '0;
         col_data_q   <= '0;
         frame_done_q <= 1'b0;
         step_q       <= 1'b0;
`ifdef GAME_SCANNER_BLANK_EN
         blank_q      <= '0;
`endif
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         dwell_q      <= dwell_d;
         fcnt_q       <= fcnt_d;
         snap_q       <= snap_d;
         row_sel_q    <= row_sel_d;
         col_data_q   <= col_data_d;
         frame_done_q <= frame_done_d;
         step_q       <= step_d;
`ifdef GAME_SCANNER_BLANK_EN
         blank_q      <= blank_d;
`endif
      end
   end

   assign row_sel    = row_sel_q;
   assign col_data   = col_data_q;
   assign frame_done = frame_done_q;
   assign step       = step_q;

endmodule
